sp_sram_bank_req_arb: RTL and testbench

//  Request front-end for one 2048x128 SP SRAM bank wrapper. Arbitrates a narrow 32b core port (A)
//  and a wide 128b line port (B, DMA/cache refill) onto the single bank interface. It drives
//  en/addr/we/be/wdata/narrow_access into the bank and returns read data with rvalid.

---
 rtl/sp_sram_bank_req_arb.sv | 181 ++++++++++++++++++
 tb/tb_sp_sram_bank_req_arb.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_sram_bank_req_arb.sv
// Request front-end for one 2048x128 single-port SRAM bank.
// Arbitrates a narrow 32b core port (A) and a wide 128b line port (B)
// onto the bank, and routes read data back with response valids.
// Port A responses are unconditional one cycle after grant; port B has
// response backpressure and keeps at most one transaction outstanding.
//
// B response FSM
//   state  | meaning
//   B_IDLE | no B transaction outstanding
//   B_WAIT | B issued last cycle; response shown straight from the bank
//   B_HOLD | response stalled by b_rready=0; shown from the hold register
module sp_sram_bank_req_arb #(
    parameter int   AW      = 11,
    parameter logic RR_INIT = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    // narrow port
    input  logic          a_req,
    output logic          a_gnt,
    input  logic [AW+1:0] a_addr,
    input  logic          a_we,
    input  logic [3:0]    a_be,
    input  logic [31:0]   a_wdata,
    output logic          a_rvalid,
    output logic [31:0]   a_rdata,
    // wide port
    input  logic          b_req,
    output logic          b_gnt,
    input  logic [AW-1:0] b_addr,
    input  logic          b_we,
    input  logic [15:0]   b_be,
    input  logic [127:0]  b_wdata,
    output logic          b_rvalid,
    input  logic          b_rready,
    output logic [127:0]  b_rdata,
    // bank interface
    output logic          mem_en,
    output logic [AW+1:0] mem_addr,
    output logic          mem_we,
    output logic [15:0]   mem_be,
    output logic [127:0]  mem_wdata,
    output logic          mem_narrow,
    input  logic [127:0]  mem_rdata
);

    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_WAIT = 2'd1,
        B_HOLD = 2'd2
    } b_state_t;

    b_state_t      b_state;
    b_state_t      b_state_nxt;
    logic          rr;
    logic          b_busy;
    logic          b_ok;
    logic          contest;
    logic          tag_v;
    logic          tag_b;
    logic          tag_we;
    logic [127:0]  hold_q;

    // B may issue a new request in the same cycle its previous response is accepted.
    assign b_busy   = (b_state != B_IDLE);
    assign b_rvalid = b_busy;
    assign b_ok     = !b_busy || (b_rvalid && b_rready);

    // Grant decision: round-robin pointer only matters when both ports are eligible.
    always_comb begin
        contest = a_req && b_req && b_ok;
        a_gnt   = a_req && (!(b_req && b_ok) || !rr);
        b_gnt   = b_req && b_ok && (!a_req || rr);
    end

    // Bank drive; everything quiet when nothing is granted.
    always_comb begin
        mem_en     = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_be     = '0;
        mem_wdata  = '0;
        mem_narrow = 1'b0;
        if (a_gnt) begin
            mem_en     = 1'b1;
            mem_narrow = 1'b1;
            mem_addr   = a_addr;
            mem_we     = a_we;
            mem_be     = {12'b0, a_be};
            mem_wdata  = {96'b0, a_wdata};
        end else if (b_gnt) begin
            mem_en     = 1'b1;
            mem_narrow = 1'b0;
            mem_addr   = {b_addr, 2'b00};
            mem_we     = b_we;
            mem_be     = b_be;
            mem_wdata  = b_wdata;
        end
    end

    // Round-robin pointer flips to the loser after every contested grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= RR_INIT;
        end else if (contest) begin
            rr <= ~rr;
        end
    end

    // One-cycle issue tag so the response cycle knows which port and kind it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v  <= 1'b0;
            tag_b  <= 1'b0;
            tag_we <= 1'b0;
        end else begin
            tag_v  <= a_gnt || b_gnt;
            tag_b  <= b_gnt;
            tag_we <= b_gnt ? b_we : a_we;
        end
    end

    // A response: bank data passed straight through in the cycle after issue.
    always_comb begin
        a_rvalid = tag_v && !tag_b;
        a_rdata  = '0;
        if (a_rvalid && !tag_we) begin
            a_rdata = mem_rdata[31:0];
        end
    end

    // B response state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_state <= B_IDLE;
        end else begin
            b_state <= b_state_nxt;
        end
    end

    // B response next state and data select. WAIT is only ever entered the
    // cycle after a B issue, so the tag describes the B access there.
    always_comb begin
        b_state_nxt = b_state;
        b_rdata     = '0;
        case (b_state)
            B_IDLE: begin
                if (b_gnt) begin
                    b_state_nxt = B_WAIT;
                end
            end
            B_WAIT: begin
                b_rdata = tag_we ? 128'b0 : mem_rdata;
                if (b_rready) begin
                    b_state_nxt = b_gnt ? B_WAIT : B_IDLE;
                end else begin
                    b_state_nxt = B_HOLD;
                end
            end
            B_HOLD: begin
                b_rdata = hold_q;
                if (b_rready) begin
                    b_state_nxt = b_gnt ? B_WAIT : B_IDLE;
                end
            end
            default: begin
                b_state_nxt = B_IDLE;
            end
        endcase
    end

    // Capture the stalled response so later A traffic on the bank cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (b_state == B_WAIT && !b_rready) begin
            hold_q <= b_rdata;
        end
    end

endmodule

// File: tb/tb_sp_sram_bank_req_arb.sv
// Scoreboard bench for sp_sram_bank_req_arb: a behavioural bank model,
// a reference memory and arbitration model push expected responses,
// and an independent monitor pops and compares them.
module tb_sp_sram_bank_req_arb;

    localparam int   AW      = 11;
    localparam logic RR_INIT = 1'b0;
    localparam int   ROWS    = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, a_gnt, a_we = 1'b0, a_rvalid;
    logic [AW+1:0] a_addr = '0;
    logic [3:0]    a_be = '0;
    logic [31:0]   a_wdata = '0, a_rdata;
    logic          b_req = 1'b0, b_gnt, b_we = 1'b0, b_rvalid, b_rready = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [15:0]   b_be = '0;
    logic [127:0]  b_wdata = '0, b_rdata;
    logic          mem_en, mem_we, mem_narrow;
    logic [AW+1:0] mem_addr;
    logic [15:0]   mem_be;
    logic [127:0]  mem_wdata, mem_rdata;

    sp_sram_bank_req_arb #(.AW(AW), .RR_INIT(RR_INIT)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_gnt(a_gnt), .a_addr(a_addr), .a_we(a_we), .a_be(a_be),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_gnt(b_gnt), .b_addr(b_addr), .b_we(b_we), .b_be(b_be),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rready(b_rready), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_narrow(mem_narrow), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic [127:0] data;
    } rsp_t;

    rsp_t a_q[$];
    rsp_t b_q[$];

    logic [127:0] bank_mem [0:ROWS-1];
    logic [127:0] ref_mem  [0:ROWS-1];

    // model state
    logic m_rr;
    logic m_bpend;
    logic last_ea, last_eb;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural SRAM bank: read data appears one cycle after en, garbage otherwise.
    always @(posedge clk) begin
        mem_rdata <= rand128();
        if (mem_en === 1'b1) begin
            if (mem_we) begin
                if (mem_narrow) begin
                    for (int i = 0; i < 4; i++)
                        if (mem_be[i])
                            bank_mem[mem_addr[AW+1:2]][32*mem_addr[1:0] + 8*i +: 8] <= mem_wdata[8*i +: 8];
                end else begin
                    for (int i = 0; i < 16; i++)
                        if (mem_be[i])
                            bank_mem[mem_addr[AW+1:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end else if (mem_narrow) begin
                mem_rdata <= {rand128() >> 32, bank_mem[mem_addr[AW+1:2]][32*mem_addr[1:0] +: 32]};
            end else begin
                mem_rdata <= bank_mem[mem_addr[AW+1:2]];
            end
        end
    end

    // Reference: who should win, what the bank should see, and what response is owed.
    task automatic model_cycle();
        bit ea, eb, bok, con;
        int row, lane;
        logic [127:0] exp;
        bok = !m_bpend || b_rready;
        con = a_req && b_req && bok;
        ea  = a_req && (!(b_req && bok) || m_rr == 1'b0);
        eb  = b_req && bok && (!a_req || m_rr == 1'b1);
        chk("a_gnt", 128'(a_gnt), 128'(ea));
        chk("b_gnt", 128'(b_gnt), 128'(eb));
        if (ea) begin
            row  = int'(a_addr[AW+1:2]);
            lane = int'(a_addr[1:0]);
            chk("a_mem_en", 128'(mem_en), 128'(1));
            chk("a_mem_narrow", 128'(mem_narrow), 128'(1));
            chk("a_mem_addr", 128'(mem_addr), 128'(a_addr));
            chk("a_mem_we", 128'(mem_we), 128'(a_we));
            chk("a_mem_be", 128'(mem_be), 128'(a_be));
            chk("a_mem_wdata", mem_wdata, 128'(a_wdata));
            exp = '0;
            if (a_we) begin
                for (int i = 0; i < 4; i++)
                    if (a_be[i]) ref_mem[row][32*lane + 8*i +: 8] = a_wdata[8*i +: 8];
            end else begin
                exp = 128'(ref_mem[row][32*lane +: 32]);
            end
            a_q.push_back('{cyc + 1, exp});
        end else if (eb) begin
            row = int'(b_addr);
            chk("b_mem_en", 128'(mem_en), 128'(1));
            chk("b_mem_narrow", 128'(mem_narrow), 128'(0));
            chk("b_mem_addr", 128'(mem_addr), 128'(row * 4));
            chk("b_mem_we", 128'(mem_we), 128'(b_we));
            chk("b_mem_be", 128'(mem_be), 128'(b_be));
            chk("b_mem_wdata", mem_wdata, b_wdata);
            exp = '0;
            if (b_we) begin
                for (int i = 0; i < 16; i++)
                    if (b_be[i]) ref_mem[row][8*i +: 8] = b_wdata[8*i +: 8];
            end else begin
                exp = ref_mem[row];
            end
            b_q.push_back('{cyc + 1, exp});
        end else begin
            chk("idle_mem_en", 128'(mem_en), 128'(0));
            chk("idle_mem_we", 128'(mem_we), 128'(0));
        end
        if (con) m_rr = !m_rr;
        if (eb) m_bpend = 1'b1;
        else if (b_rready) m_bpend = 1'b0;
        last_ea = ea;
        last_eb = eb;
    endtask

    // Monitor: pops expected responses whenever the DUT presents one.
    always @(negedge clk) begin
        if (a_rvalid === 1'b1) begin
            if (a_q.size() == 0 || a_q[0].due != cyc) begin
                checks++; errors++;
                $display("FAIL a_rvalid_unexpected actual=1 expected=0 cyc=%0d", cyc);
            end else begin
                chk("a_rdata", 128'(a_rdata), a_q[0].data);
                void'(a_q.pop_front());
            end
        end else if (a_q.size() > 0 && a_q[0].due <= cyc) begin
            checks++; errors++;
            $display("FAIL a_rvalid_missing actual=%b expected=1 cyc=%0d", a_rvalid, cyc);
            void'(a_q.pop_front());
        end
        if (b_rvalid === 1'b1) begin
            if (b_q.size() == 0 || b_q[0].due > cyc) begin
                checks++; errors++;
                $display("FAIL b_rvalid_unexpected actual=1 expected=0 cyc=%0d", cyc);
            end else begin
                chk("b_rdata", b_rdata, b_q[0].data);
                if (b_rready) void'(b_q.pop_front());
            end
        end else if (b_q.size() > 0 && b_q[0].due <= cyc) begin
            checks++; errors++;
            $display("FAIL b_rvalid_missing actual=%b expected=1 cyc=%0d", b_rvalid, cyc);
            void'(b_q.pop_front());
        end
    end

    // Timing: inputs change at posedge+1, model compares at posedge+3.
    task automatic settle();
        #2;
    endtask

    task automatic adv();
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        settle();
        adv();
    endtask

    task automatic idle(input int n);
        a_req = 1'b0; b_req = 1'b0; b_rready = 1'b1;
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; a_req = 1'b0; b_req = 1'b0; b_rready = 1'b0;
        tick();
        a_q.delete(); b_q.delete();
        m_rr = RR_INIT; m_bpend = 1'b0;
        repeat (n - 1) tick();
        rst = 1'b0;
    endtask

    task automatic set_a(input logic req, input logic [AW+1:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wd);
        a_req = req; a_addr = addr; a_we = we; a_be = be; a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic [AW-1:0] addr, input logic we,
                         input logic [15:0] be, input logic [127:0] wd);
        b_req = req; b_addr = addr; b_we = we; b_be = be; b_wdata = wd;
    endtask

    initial begin
        logic [127:0] v;
        for (int i = 0; i < ROWS; i++) begin
            v = rand128();
            bank_mem[i] <= v;
            ref_mem[i] = v;
        end
        m_rr = RR_INIT; m_bpend = 1'b0; last_ea = 1'b0; last_eb = 1'b0;
        @(posedge clk);
        #1;
        do_reset(3);
        chk("rst_a_rvalid", 128'(a_rvalid), 128'(0));
        chk("rst_b_rvalid", 128'(b_rvalid), 128'(0));
        chk("rst_a_rdata", 128'(a_rdata), 128'(0));
        chk("rst_b_rdata", b_rdata, 128'(0));

        // narrow read, lane 2 of row 5
        b_rready = 1'b1;
        set_a(1'b1, {11'h005, 2'd2}, 1'b0, 4'hF, 32'h0);
        settle();
        chk("dir_a_mem_addr", 128'(mem_addr), 128'(13'h016));
        chk("dir_a_mem_narrow", 128'(mem_narrow), 128'(1));
        adv();
        set_a(1'b0, '0, 1'b0, 4'h0, 32'h0);
        tick();
        idle(2);

        // wide write then readback
        v = rand128();
        set_b(1'b1, 11'h010, 1'b1, 16'hFFFF, v);
        settle();
        chk("dir_b_mem_addr", 128'(mem_addr), 128'(13'h040));
        chk("dir_b_mem_narrow", 128'(mem_narrow), 128'(0));
        adv();
        set_b(1'b1, 11'h010, 1'b0, 16'h0, '0);
        tick();
        idle(3);

        // contention from reset pointer: A, B, A, B
        do_reset(2);
        set_a(1'b1, {11'h003, 2'd1}, 1'b0, 4'hF, 32'h0);
        set_b(1'b1, 11'h004, 1'b0, 16'h0, '0);
        b_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("cont_a_gnt", 128'(a_gnt), 128'(i % 2 == 0));
            chk("cont_b_gnt", 128'(b_gnt), 128'(i % 2 == 1));
            adv();
        end
        idle(3);

        // B backpressure while A reads every cycle
        set_b(1'b1, 11'h020, 1'b0, 16'h0, '0);
        tick();
        set_b(1'b1, 11'h021, 1'b0, 16'h0, '0);
        b_rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_a(1'b1, {11'h008, 2'(i)}, 1'b0, 4'hF, 32'h0);
            settle();
            chk("bp_b_gnt", 128'(b_gnt), 128'(0));
            chk("bp_a_gnt", 128'(a_gnt), 128'(1));
            chk("bp_b_rvalid", 128'(b_rvalid), 128'(1));
            adv();
        end
        set_a(1'b0, '0, 1'b0, 4'h0, 32'h0);
        b_rready = 1'b1;
        settle();
        chk("bp_release_b_gnt", 128'(b_gnt), 128'(1));
        adv();
        idle(3);

        // back-to-back B with b_rready high
        for (int i = 0; i < 4; i++) begin
            set_b(1'b1, 11'(i + 2), 1'(i % 2), 16'h0F0F, rand128());
            settle();
            chk("b2b_b_gnt", 128'(b_gnt), 128'(1));
            if (i > 0) chk("b2b_b_rvalid", 128'(b_rvalid), 128'(1));
            adv();
        end
        b_req = 1'b0;
        settle();
        chk("b2b_last_rvalid", 128'(b_rvalid), 128'(1));
        adv();
        idle(2);

        // reset with A and B responses in flight
        b_rready = 1'b0;
        set_b(1'b1, 11'h011, 1'b0, 16'h0, '0);
        tick();
        b_req = 1'b0;
        set_a(1'b1, {11'h012, 2'd3}, 1'b0, 4'hF, 32'h0);
        tick();
        set_a(1'b0, '0, 1'b0, 4'h0, 32'h0);
        do_reset(1);
        chk("mid_rst_a_rvalid", 128'(a_rvalid), 128'(0));
        chk("mid_rst_b_rvalid", 128'(b_rvalid), 128'(0));
        set_a(1'b1, {11'h001, 2'd0}, 1'b0, 4'hF, 32'h0);
        set_b(1'b1, 11'h002, 1'b0, 16'h0, '0);
        b_rready = 1'b1;
        settle();
        chk("post_rst_first_a_gnt", 128'(a_gnt), 128'(1));
        adv();
        tick();
        idle(3);

        // randomized traffic; requests held until granted
        a_req = 1'b0; b_req = 1'b0; last_ea = 1'b0; last_eb = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!a_req || last_ea) begin
                a_req   = ($urandom_range(0, 9) < 6);
                a_addr  = (AW+2)'($urandom_range(0, 63));
                a_we    = 1'($urandom);
                a_be    = 4'($urandom);
                a_wdata = $urandom;
            end
            if (!b_req || last_eb) begin
                b_req   = ($urandom_range(0, 9) < 5);
                b_addr  = AW'($urandom_range(0, 15));
                b_we    = 1'($urandom);
                b_be    = 16'($urandom);
                b_wdata = rand128();
            end
            b_rready = ($urandom_range(0, 9) < 7);
            tick();
        end
        idle(4);
        chk("drain_a_q", 128'(a_q.size()), 128'(0));
        chk("drain_b_q", 128'(b_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
